// File: rtl/axil_tt_pkg.sv
// axil_tt_pkg: shared response codes, FSM state types and address field positions
package axil_tt_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int A_LSB = 5;
  localparam int B_LSB = 2;
  typedef enum logic [1:0] {R_IDLE, R_CALC, R_PIPE, R_RESP} rstate_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
endpackage

// File: rtl/tt_mult3.sv
// tt_mult3: registered 3x3 -> 6-bit multiplier, loads only when enabled
module tt_mult3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);
  always_ff @(posedge clk) begin
    if (rst) p <= '0;
    else if (en) p <= {3'b0, a} * {3'b0, b};
  end
endmodule

// File: rtl/axil_times_table_slave.sv
// axil_times_table_slave: read-only AXI4-Lite 8x8 times table; `define TT_PIPE_EN adds a read pipeline stage
module axil_times_table_slave
  import axil_tt_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready
);
  rstate_t rstate;
  wstate_t wstate;
  logic [2:0] a, b;
  logic [5:0] prod, src, rd;
  logic aw_done, w_done, aw_got, w_got;
  logic unused;
  assign unused = ^{s_axi_araddr[1:0], s_axi_awaddr, s_axi_wdata, s_axi_wstrb};
  assign s_axi_arready = rstate == R_IDLE;
  assign s_axi_rdata = DATA_W'(rd);
  assign s_axi_rresp = RESP_OKAY;
  tt_mult3 u_mult (
    .clk(clk),
    .rst(rst),
    .en(rstate == R_CALC),
    .a(a),
    .b(b),
    .p(prod)
  );
`ifdef TT_PIPE_EN
  logic [5:0] pipe;
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else if (rstate == R_PIPE) pipe <= prod;
  end
  assign src = pipe;
`else
  assign src = prod;
`endif
  // rvalid rises one cycle into R_RESP, when rd captures the product
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      a <= '0;
      b <= '0;
      rd <= '0;
      s_axi_rvalid <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (s_axi_arvalid) begin
          a <= s_axi_araddr[A_LSB +: 3];
          b <= s_axi_araddr[B_LSB +: 3];
          rstate <= R_CALC;
        end
`ifdef TT_PIPE_EN
        R_CALC: rstate <= R_PIPE;
        R_PIPE: rstate <= R_RESP;
`else
        R_CALC: rstate <= R_RESP;
`endif
        R_RESP: if (!s_axi_rvalid) begin
          s_axi_rvalid <= 1'b1;
          rd <= src;
        end else if (s_axi_rready) begin
          s_axi_rvalid <= 1'b0;
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
  assign s_axi_awready = wstate == W_IDLE && !aw_done;
  assign s_axi_wready = wstate == W_IDLE && !w_done;
  assign s_axi_bvalid = wstate == W_RESP;
  assign aw_got = aw_done || s_axi_awvalid;
  assign w_got = w_done || s_axi_wvalid;
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
    end else if (wstate == W_IDLE) begin
      if (aw_got && w_got) begin
        wstate <= W_RESP;
        s_axi_bresp <= RESP_SLVERR;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end else begin
        aw_done <= aw_got;
        w_done <= w_got;
      end
    end else if (s_axi_bready) wstate <= W_IDLE;
  end
endmodule
